fetch_sequencer: RTL
====================

Name: fetch_sequencer

Overview:
- Sequences the processor's instruction memory: owns the program counter, drives the memory read address, registers the returned word, and hands it to decode over a valid/ready handshake.
- Handles jump/branch redirects, the HALT opcode, a boot wait that covers memory initialisation, and address-range/alignment faults.
- Sits between instruction memory (combinational read, byte-addressed, word slots at multiples of 4) and the decode stage.

Parameters:
- START_ADDR, 0, byte address loaded into PC on start.
- ADDR_LIMIT, 268, highest legal word-aligned byte address.
- BOOT_CYCLES, 2, clock cycles spent in BOOT before the first fetch (must be at least 1).
- HALT_OPCODE, 5'b10000, value of instr[31:27] that stops fetch.
- FETCH_LIMIT, 1024, maximum accepted instructions (used only with the optional feature).

Ports:
- clk  in  1  sole clock; all state updates on posedge.
- rst_n  in  1  asynchronous, active-low reset.
- start  in  1  one-cycle pulse; leaves IDLE or HALT.
- imem_addr  out  32  read address to instruction memory; always equals pc.
- imem_rdata  in  32  combinational read data for imem_addr.
- instr_out  out  32  registered instruction to decode.
- instr_pc  out  32  byte address of instr_out.
- instr_valid  out  1  instr_out holds a live instruction.
- instr_ready  in  1  decode accepts instr_out this cycle.
- redirect_valid  in  1  jump/branch taken.
- redirect_target  in  32  byte target address.
- running  out  1  FSM is in RUN.
- halted  out  1  FSM is in HALT.
- fault  out  2  sticky fault code: 0 none, 1 misaligned, 2 out-of-range, 3 fetch-limit.
- retired  out  32  saturating count of accepted instructions.

Behaviour:
- Reset (async, rst_n=0): state IDLE; pc=START_ADDR; instr_out=0; instr_pc=0; instr_valid=0; fault=0; retired=0; boot counter=0; running=0; halted=0.
- IDLE:
  - start -> BOOT; boot counter is cleared.
- BOOT:
  - Counts BOOT_CYCLES cycles, then -> RUN with pc=START_ADDR.
  - No fetches issue during BOOT.
- RUN, fetch issue: an issue occurs when instr_valid=0, or when instr_valid=1 and instr_ready=1. On issue:
  - instr_out<=imem_rdata, instr_pc<=pc, instr_valid<=1, pc<=pc+4.
  - Latency: one cycle from pc to instr_valid.
  - Throughput: one instruction per cycle while instr_ready=1.
- Stall: instr_valid=1 and instr_ready=0 -> instr_out, instr_pc and pc are all held.
- Accept: instr_valid=1 and instr_ready=1 -> retired increments, saturating at 32'hFFFFFFFF.
- Redirect: redirect_valid=1 in cycle t has priority over issue and over stall.
  - pc<=redirect_target; instr_valid<=0 at t+1.
  - The current instr_out counts as accepted only if instr_ready=1 in cycle t.
  - The first target instruction is valid at t+2.
  - redirect_valid is ignored outside RUN.
- Halt:
  - An accepted instruction with instr[31:27]==HALT_OPCODE -> HALT next cycle; instr_valid<=0; pc frozen; no further issue.
  - A redirect in the same cycle as the HALT accept is ignored.
- HALT:
  - start -> BOOT; pc reloads to START_ADDR; fault and retired are cleared.
  - All other inputs are ignored.
- Faults: each one sets fault, drops instr_valid and enters HALT next cycle.
  - Misaligned: redirect_target[1:0]!=0 -> fault=1.
  - Out-of-range: an issue would use pc>ADDR_LIMIT, or redirect_target>ADDR_LIMIT -> fault=2. No read of an out-of-range address is ever registered.
  - Priority when simultaneous: misaligned, then out-of-range, then halt.
- start while in RUN or BOOT: ignored.
- running=(state==RUN); halted=(state==HALT); both are registered-state decodes.

Optional Feature:
- Macro: FETCH_LIMIT_EN.
- Defined: when retired reaches FETCH_LIMIT on an accept, the block enters HALT with fault=3 (runaway-loop guard).
- Undefined: no limit logic is compiled; fault code 3 is never produced.

Decomposition:
- Shared package (fetch_pkg): state encoding (IDLE, BOOT, RUN, HALT), fault code constants, HALT_OPCODE default, opcode field bounds [31:27].
- No sub-module: PC, FSM and the output register fit in one module.

Test Plan:
- Sequential fetch: reset, start, memory holds 0x08000001 at 0/4/8, instr_ready=1 -> after BOOT_CYCLES, instr_valid rises with instr_pc 0, 4, 8 on consecutive cycles; retired=3 after three accepts.
- Stall: instr_ready=0 for 3 cycles at instr_pc=4 -> instr_out and pc are held; retired unchanged; issue resumes at 8 when ready returns.
- Redirect: redirect_valid with target 24 while instr_pc=12 -> instr_valid=0 the next cycle; instr_pc=24 valid one cycle later.
- Halt: 0x80000000 at address 24 accepted -> halted=1, instr_valid=0, pc frozen; start -> BOOT, then fetch from 0 with retired=0.
- Faults: redirect_target=26 -> fault=1, halted=1. Sequential run to 268 with a non-halt word -> fault=2, and no instruction from 272 is ever valid.
- Async reset mid-RUN with instr_valid=1 -> all outputs return to reset values immediately, with no clock edge required.

Source files
------------

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM encoding,
// fault codes, and the opcode field used to detect HALT.
package fetch_pkg;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_BOOT = 2'd1;
   localparam logic [1:0] ST_RUN  = 2'd2;
   localparam logic [1:0] ST_HALT = 2'd3;

   typedef enum logic [1:0] {
      FAULT_NONE     = 2'd0,
      FAULT_MISALIGN = 2'd1,
      FAULT_RANGE    = 2'd2,
      FAULT_LIMIT    = 2'd3
   } fault_e;

   localparam int unsigned OPC_MSB         = 31;
   localparam int unsigned OPC_LSB         = 27;
   localparam logic [4:0]  HALT_OPCODE_DEF = 5'b10000;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port plus the decode handshake and redirect request.
interface fetch_sequencer_if;
   logic [31:0] imem_addr;
   logic [31:0] imem_rdata;
   logic [31:0] instr_out;
   logic [31:0] instr_pc;
   logic        instr_valid;
   logic        instr_ready;
   logic        redirect_valid;
   logic [31:0] redirect_target;

   modport master (
      output imem_addr, instr_out, instr_pc, instr_valid,
      input  imem_rdata, instr_ready, redirect_valid, redirect_target
   );

   modport slave (
      input  imem_addr, instr_out, instr_pc, instr_valid,
      output imem_rdata, instr_ready, redirect_valid, redirect_target
   );
endinterface

// File: rtl/fetch_sequencer.sv
// Fetch sequencer: PC, boot wait, fetch/handshake FSM and fault capture.
// Optional runaway guard enabled by defining FETCH_LIMIT_EN.
//
// state   | meaning
// IDLE    | after reset, waiting for start
// BOOT    | memory settling, BOOT_CYCLES cycles, no fetch
// RUN     | fetching one word per cycle toward decode
// HALT    | stopped by HALT opcode or a fault, waiting for start
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter logic [31:0] START_ADDR  = 32'd0,
   parameter logic [31:0] ADDR_LIMIT  = 32'd268,
   parameter int unsigned BOOT_CYCLES = 2,
   parameter logic [4:0]  HALT_OPCODE = HALT_OPCODE_DEF
`ifdef FETCH_LIMIT_EN
   ,
   parameter int unsigned FETCH_LIMIT = 1024
`endif
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   fetch_sequencer_if.master  bus,
   output logic               running,
   output logic               halted,
   output logic [1:0]         fault,
   output logic [31:0]        retired
);

   localparam int unsigned BOOT_W = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;
   localparam logic [BOOT_W-1:0] BOOT_LAST = BOOT_W'(BOOT_CYCLES - 1);

   logic [1:0]        state_q, state_d;
   logic [31:0]       pc_q, pc_d;
   logic [31:0]       instr_q, instr_d;
   logic [31:0]       ipc_q, ipc_d;
   logic              valid_q, valid_d;
   logic [1:0]        fault_q, fault_d;
   logic [31:0]       retired_q, retired_d;
   logic [BOOT_W-1:0] boot_q, boot_d;

   logic issue, accept, halt_acc, redir_mis, redir_oor, issue_oor, limit_hit;

   assign issue     = !valid_q || bus.instr_ready;
   assign accept    = valid_q && bus.instr_ready;
   assign halt_acc  = accept && (instr_q[OPC_MSB:OPC_LSB] == HALT_OPCODE);
   assign redir_mis = bus.redirect_valid && (bus.redirect_target[1:0] != 2'b00);
   assign redir_oor = bus.redirect_valid && (bus.redirect_target > ADDR_LIMIT);
   // A redirect pre-empts the sequential issue, so only then can pc itself be out of range.
   assign issue_oor = !bus.redirect_valid && issue && (pc_q > ADDR_LIMIT);

`ifdef FETCH_LIMIT_EN
   assign limit_hit = accept && (({1'b0, retired_q} + 33'd1) == 33'(FETCH_LIMIT));
`else
   assign limit_hit = 1'b0;
`endif

   always_comb begin
      state_d   = state_q;
      pc_d      = pc_q;
      instr_d   = instr_q;
      ipc_d     = ipc_q;
      valid_d   = valid_q;
      fault_d   = fault_q;
      retired_d = retired_q;
      boot_d    = boot_q;
      case (state_q)
         ST_IDLE: begin
            if (start) begin
               state_d = ST_BOOT;
               boot_d  = '0;
            end
         end
         ST_BOOT: begin
            if (boot_q == BOOT_LAST) begin
               state_d = ST_RUN;
               pc_d    = START_ADDR;
            end else begin
               boot_d = boot_q + 1'b1;
            end
         end
         ST_RUN: begin
            if (accept && (retired_q != 32'hFFFF_FFFF)) begin
               retired_d = retired_q + 32'd1;
            end
            if (redir_mis) begin
               fault_d = FAULT_MISALIGN;
               valid_d = 1'b0;
               state_d = ST_HALT;
            end else if (redir_oor || issue_oor) begin
               fault_d = FAULT_RANGE;
               valid_d = 1'b0;
               state_d = ST_HALT;
            end else if (limit_hit) begin
               fault_d = FAULT_LIMIT;
               valid_d = 1'b0;
               state_d = ST_HALT;
            end else if (halt_acc) begin
               valid_d = 1'b0;
               state_d = ST_HALT;
            end else if (bus.redirect_valid) begin
               pc_d    = bus.redirect_target;
               valid_d = 1'b0;
            end else if (issue) begin
               instr_d = bus.imem_rdata;
               ipc_d   = pc_q;
               valid_d = 1'b1;
               pc_d    = pc_q + 32'd4;
            end
         end
         ST_HALT: begin
            if (start) begin
               state_d   = ST_BOOT;
               pc_d      = START_ADDR;
               fault_d   = FAULT_NONE;
               retired_d = '0;
               boot_d    = '0;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= ST_IDLE;
         pc_q      <= START_ADDR;
         instr_q   <= '0;
         ipc_q     <= '0;
         valid_q   <= 1'b0;
         fault_q   <= FAULT_NONE;
         retired_q <= '0;
         boot_q    <= '0;
      end else begin
         state_q   <= state_d;
         pc_q      <= pc_d;
         instr_q   <= instr_d;
         ipc_q     <= ipc_d;
         valid_q   <= valid_d;
         fault_q   <= fault_d;
         retired_q <= retired_d;
         boot_q    <= boot_d;
      end
   end

   assign bus.imem_addr   = pc_q;
   assign bus.instr_out   = instr_q;
   assign bus.instr_pc    = ipc_q;
   assign bus.instr_valid = valid_q;
   assign running         = (state_q == ST_RUN);
   assign halted          = (state_q == ST_HALT);
   assign fault           = fault_q;
   assign retired         = retired_q;

endmodule
